rx_stream_ctrl: RTL and testbench

RX_STREAM_CTRL -- requirements
Module: rx_stream_ctrl

---
 rtl/usb_rx_pkg.sv | 27 ++
 rtl/rx_sync_det.sv | 82 ++++++++
 rtl/rx_stream_ctrl.sv | 148 ++++++++++++++
 tb/tb_rx_stream_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_rx_pkg
//  Description : Shared definitions for the receive stream controller.
//                Holds the controller state encoding, the sync byte pattern,
//                the sync hunt timeout and the maximum packet length in bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HUNT   = 3'd1,
      PACKET = 3'd2,
      EOP1   = 3'd3,
      EOP2   = 3'd4
   } rx_state_e;

   // Seven zeros followed by a one, in arrival order (newest bit in LSB).
   localparam logic [7:0]  SYNC_PATTERN = 8'b0000_0001;
   // Strobes allowed in HUNT before giving up on a sync.
   localparam logic [15:0] SYNC_TIMEOUT = 16'd64;
   // Largest number of packet bits that may be forwarded.
   localparam logic [10:0] MAX_PKT_BITS = 11'd1030;

endpackage : usb_rx_pkg
`default_nettype wire

// File: rtl/rx_sync_det.sv
`default_nettype none
// ============================================================================
//  Module      : rx_sync_det
//  Description : Sync detector. Shifts line bits into an 8-bit register and
//                flags a match against SYNC_PATTERN; counts strobes and flags
//                a timeout when SYNC_TIMEOUT strobes pass without a match.
//  Ports       : clk, rst_b      - clock, async active-low reset
//                clear           - synchronous clear of all detector state
//                enable          - detector active (controller in HUNT)
//                bit_in          - line bit
//                bit_valid, se0  - bit strobe and SE0 line condition
//                match           - combinational: this strobe completes sync
//                timeout         - combinational: this strobe exhausts budget
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_sync_det
   import usb_rx_pkg::*;
(
   input  logic clk,
   input  logic rst_b,
   input  logic clear,
   input  logic enable,
   input  logic bit_in,
   input  logic bit_valid,
   input  logic se0,
   output logic match,
   output logic timeout
);

   logic [7:0]  shift_q, shift_d;
   logic [3:0]  fill_q, fill_d;
   logic [15:0] strobe_cnt_q, strobe_cnt_d;

   logic [7:0]  shift_next;
   logic [3:0]  fill_next;
   logic [15:0] cnt_next;

   // The fill count keeps a freshly cleared (all-zero) register from
   // matching on the very first '1': a match needs eight real bits.
   always_comb begin
      shift_d      = shift_q;
      fill_d       = fill_q;
      strobe_cnt_d = strobe_cnt_q;
      match        = 1'b0;
      timeout      = 1'b0;
      shift_next   = {shift_q[6:0], bit_in};
      fill_next    = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;
      cnt_next     = strobe_cnt_q + 16'd1;

      if (clear) begin
         shift_d      = '0;
         fill_d       = '0;
         strobe_cnt_d = '0;
      end else if (enable && bit_valid) begin
         strobe_cnt_d = cnt_next;
         if (se0) begin
            shift_d = '0;
            fill_d  = '0;
         end else begin
            shift_d = shift_next;
            fill_d  = fill_next;
            match   = (fill_next == 4'd8) && (shift_next == SYNC_PATTERN);
         end
         // A match on the last allowed strobe still wins.
         timeout = !match && (cnt_next == SYNC_TIMEOUT);
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         shift_q      <= '0;
         fill_q       <= '0;
         strobe_cnt_q <= '0;
      end else begin
         shift_q      <= shift_d;
         fill_q       <= fill_d;
         strobe_cnt_q <= strobe_cnt_d;
      end
   end

endmodule : rx_sync_det
`default_nettype wire

// File: rtl/rx_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rx_stream_ctrl
//  Description : Receive stream controller. Hunts for the sync pattern,
//                forwards packet bits to the unstuffer with zero latency,
//                checks the SE0,SE0,J end-of-packet and limits packet length.
//  Ports       : clk, rst_b      - clock, async active-low reset
//                rx_en           - permits a new packet hunt while high
//                bit_in          - decoded line bit
//                bit_valid       - one-cycle strobe per bit time
//                se0             - line in SE0, sampled with bit_valid
//                bstr_out        - packet bit to unstuffer (always = bit_in)
//                bstr_out_avail  - qualifies bstr_out
//                out_done        - registered pulse on good end of packet
//                rx_err          - registered pulse on sync timeout, bad EOP
//                                  or length overflow
//                busy            - high whenever not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_stream_ctrl
   import usb_rx_pkg::*;
(
   input  logic clk,
   input  logic rst_b,
   input  logic rx_en,
   input  logic bit_in,
   input  logic bit_valid,
   input  logic se0,
   output logic bstr_out,
   output logic bstr_out_avail,
   output logic out_done,
   output logic rx_err,
   output logic busy
);

   rx_state_e   state_q, state_d;
   logic [10:0] pkt_cnt_q, pkt_cnt_d;
   logic        out_done_q, out_done_d;
   logic        rx_err_q, rx_err_d;

   logic        sync_clear;
   logic        sync_enable;
   logic        sync_match;
   logic        sync_timeout;

   // Holding the detector clear throughout IDLE guarantees a fresh start
   // on every entry to HUNT.
   assign sync_clear  = (state_q == IDLE);
   assign sync_enable = (state_q == HUNT);

   rx_sync_det u_sync_det (
      .clk       (clk),
      .rst_b     (rst_b),
      .clear     (sync_clear),
      .enable    (sync_enable),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .se0       (se0),
      .match     (sync_match),
      .timeout   (sync_timeout)
   );

   always_comb begin
      state_d        = state_q;
      pkt_cnt_d      = pkt_cnt_q;
      out_done_d     = 1'b0;
      rx_err_d       = 1'b0;
      bstr_out_avail = 1'b0;

      case (state_q)
         IDLE: begin
            pkt_cnt_d = '0;
            if (rx_en) state_d = HUNT;
         end

         HUNT: begin
            // Dropping rx_en abandons the hunt quietly.
            if (!rx_en) begin
               state_d = IDLE;
            end else if (bit_valid) begin
               if (sync_match) begin
                  state_d = PACKET;
               end else if (sync_timeout) begin
                  rx_err_d = 1'b1;
                  state_d  = IDLE;
               end
            end
         end

         PACKET: begin
            if (bit_valid) begin
               if (se0) begin
                  state_d = EOP1;
               end else if (pkt_cnt_q == MAX_PKT_BITS) begin
                  // Overflowing bit is dropped, not forwarded.
                  rx_err_d = 1'b1;
                  state_d  = IDLE;
               end else begin
                  bstr_out_avail = 1'b1;
                  pkt_cnt_d      = pkt_cnt_q + 11'd1;
               end
            end
         end

         EOP1: begin
            if (bit_valid) begin
               if (se0) begin
                  state_d = EOP2;
               end else begin
                  rx_err_d = 1'b1;
                  state_d  = IDLE;
               end
            end
         end

         EOP2: begin
            if (bit_valid) begin
               if (se0) rx_err_d   = 1'b1;
               else     out_done_d = 1'b1;
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q    <= IDLE;
         pkt_cnt_q  <= '0;
         out_done_q <= 1'b0;
         rx_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pkt_cnt_q  <= pkt_cnt_d;
         out_done_q <= out_done_d;
         rx_err_q   <= rx_err_d;
      end
   end

   assign bstr_out = bit_in;
   assign out_done = out_done_q;
   assign rx_err   = rx_err_q;
   assign busy     = (state_q != IDLE);

endmodule : rx_stream_ctrl
`default_nettype wire

// File: tb/tb_rx_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_stream_ctrl
//  Description : Scoreboard bench for rx_stream_ctrl. Symbol streams are
//                evaluated by a packet-level reference model; expected
//                forwarded bits and end pulses (with their cycle) are queued
//                by the driver and popped by an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_stream_ctrl;

   localparam int K_NONE = 0;
   localparam int K_BIT  = 1;
   localparam int K_DONE = 2;
   localparam int K_ERR  = 3;
   localparam int HUNT_LIMIT = 64;
   localparam int PKT_LIMIT  = 1030;

   typedef struct packed {
      logic b;
      logic s;
   } sym_t;

   typedef struct {
      int   kind;
      logic b;
      int   cyc;
   } exp_t;

   logic clk       = 1'b0;
   logic rst_b     = 1'b0;
   logic rx_en     = 1'b0;
   logic bit_in    = 1'b0;
   logic bit_valid = 1'b0;
   logic se0       = 1'b0;
   logic bstr_out;
   logic bstr_out_avail;
   logic out_done;
   logic rx_err;
   logic busy;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   exp_t exp_q[$];
   sym_t sq[$];
   int   kq[$];

   rx_stream_ctrl dut (
      .clk            (clk),
      .rst_b          (rst_b),
      .rx_en          (rx_en),
      .bit_in         (bit_in),
      .bit_valid      (bit_valid),
      .se0            (se0),
      .bstr_out       (bstr_out),
      .bstr_out_avail (bstr_out_avail),
      .out_done       (out_done),
      .rx_err         (rx_err),
      .busy           (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   task automatic observe(input int kind, input logic b);
      exp_t e;
      if (exp_q.size() == 0) begin
         check("unexpected_event", kind, K_NONE);
         return;
      end
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == K_BIT && e.kind == K_BIT) check("bit_value", int'(b), int'(e.b));
      check("event_cycle", cyc, e.cyc);
   endtask

   always @(negedge clk) begin
      if (rst_b === 1'b1) begin
         if (bit_valid) check("bstr_passthru", int'(bstr_out), int'(bit_in));
         if (out_done || rx_err) begin
            check("pulse_overlap", int'(out_done & rx_err), 0);
            check("busy_at_pulse", int'(busy), 0);
         end
         if (bstr_out_avail) observe(K_BIT, bstr_out);
         if (out_done)       observe(K_DONE, 1'b0);
         if (rx_err)         observe(K_ERR, 1'b0);
      end
   end

   // ---------------- reference model ----------------
   // Walks the symbol list at packet level; fills kq with the response each
   // symbol should produce and returns how many symbols the DUT consumes.
   function automatic int model();
      logic hist[$];
      int   i = 0;
      int   n = 0;
      bit   hit;
      bit   saw_se0 = 0;
      kq = {};
      // sync hunt
      while (1) begin
         if (i >= sq.size()) return i;
         kq.push_back(K_NONE);
         if (sq[i].s) hist = {};
         else         hist.push_back(sq[i].b);
         hit = 0;
         if (hist.size() >= 8) begin
            hit = (hist[hist.size()-1] == 1'b1);
            for (int j = 2; j <= 8; j++)
               if (hist[hist.size()-j] != 1'b0) hit = 0;
         end
         i++;
         if (hit) break;
         if (i == HUNT_LIMIT) begin
            kq[i-1] = K_ERR;
            return i;
         end
      end
      // packet body
      while (i < sq.size() && !saw_se0) begin
         if (sq[i].s) begin
            kq.push_back(K_NONE);
            saw_se0 = 1;
         end else if (n == PKT_LIMIT) begin
            kq.push_back(K_ERR);
            return i + 1;
         end else begin
            kq.push_back(K_BIT);
            n++;
         end
         i++;
      end
      // end of packet: SE0 already seen, expect SE0 then J
      if (i >= sq.size()) return i;
      if (!sq[i].s) begin
         kq.push_back(K_ERR);
         return i + 1;
      end
      kq.push_back(K_NONE);
      i++;
      if (i >= sq.size()) return i;
      kq.push_back(sq[i].s ? K_ERR : K_DONE);
      return i + 1;
   endfunction

   // ---------------- driver ----------------
   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input sym_t s, input int kind);
      exp_t e;
      if (kind != K_NONE) begin
         e.kind = kind;
         e.b    = s.b;
         e.cyc  = (kind == K_BIT) ? cyc : cyc + 1;
         exp_q.push_back(e);
      end
      bit_in    = s.b;
      se0       = s.s;
      bit_valid = 1'b1;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      bit_in    = 1'($urandom);
      se0       = 1'($urandom);
   endtask

   task automatic push_sym(input logic b, input logic s);
      sym_t x;
      x.b = b;
      x.s = s;
      sq.push_back(x);
   endtask

   task automatic push_sync();
      repeat (7) push_sym(1'b0, 1'b0);
      push_sym(1'b1, 1'b0);
   endtask

   task automatic push_data(input int n);
      repeat (n) push_sym(1'($urandom), 1'b0);
   endtask

   task automatic run_scn(input int gap_min, input int gap_max);
      int used;
      used  = model();
      rx_en = 1'b1;
      idle_cycles(1);
      for (int i = 0; i < used; i++) begin
         strobe(sq[i], kq[i]);
         idle_cycles($urandom_range(gap_max, gap_min));
      end
      rx_en = 1'b0;
      idle_cycles(3);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      sym_t x;
      int   nv;

      // reset state
      #1;
      check("reset_avail", int'(bstr_out_avail), 0);
      check("reset_done",  int'(out_done), 0);
      check("reset_err",   int'(rx_err), 0);
      check("reset_busy",  int'(busy), 0);
      idle_cycles(3);
      rst_b = 1'b1;
      idle_cycles(2);

      // nominal packet: sync, 10100101, SE0 SE0 J
      sq = {};
      push_sync();
      push_sym(1, 0); push_sym(0, 0); push_sym(1, 0); push_sym(0, 0);
      push_sym(0, 0); push_sym(1, 0); push_sym(0, 0); push_sym(1, 0);
      push_sym(0, 1); push_sym(0, 1); push_sym(1, 0);
      run_scn(0, 0);

      // sync timeout: 64 ones
      sq = {};
      repeat (64) push_sym(1, 0);
      run_scn(0, 0);

      // rx_en dropped in HUNT
      rx_en = 1'b1;
      idle_cycles(1);
      check("hunt_busy", int'(busy), 1);
      for (int i = 0; i < 5; i++) begin
         x.b = 1'($urandom); x.s = 1'b0;
         strobe(x, K_NONE);
      end
      rx_en = 1'b0;
      idle_cycles(1);
      check("hunt_abort_busy", int'(busy), 0);
      idle_cycles(2);

      // short packet with bad EOP (SE0 then J)
      sq = {};
      push_sync(); push_data(4);
      push_sym(0, 1); push_sym(1, 0);
      run_scn(0, 0);

      // length overflow: 1031 data bits
      sq = {};
      push_sync(); push_data(1031);
      run_scn(0, 0);

      // packet with 3-cycle gaps between strobes
      sq = {};
      push_sync(); push_data(12);
      push_sym(0, 1); push_sym(0, 1); push_sym(0, 0);
      run_scn(3, 3);

      // reset during packet bit 5
      sq = {};
      push_sync(); push_data(10);
      nv = model();
      rx_en = 1'b1;
      idle_cycles(1);
      for (int i = 0; i < 13; i++) strobe(sq[i], kq[i]);
      bit_in    = sq[13].b;
      se0       = 1'b0;
      bit_valid = 1'b1;
      #2;
      rst_b = 1'b0;
      #1;
      check("midrst_avail", int'(bstr_out_avail), 0);
      check("midrst_done",  int'(out_done), 0);
      check("midrst_err",   int'(rx_err), 0);
      check("midrst_busy",  int'(busy), 0);
      check("midrst_pending", exp_q.size(), 0);
      bit_valid = 1'b0;
      rx_en     = 1'b0;
      idle_cycles(2);
      rst_b = 1'b1;
      for (int i = 0; i < 6; i++) begin
         x.b = 1'($urandom); x.s = 1'($urandom);
         strobe(x, K_NONE);
      end
      rx_en = 1'b1;
      idle_cycles(1);
      for (int i = 0; i < 6; i++) begin
         x.b = 1'b1; x.s = 1'b0;
         strobe(x, K_NONE);
      end
      rx_en = 1'b0;
      idle_cycles(3);
      check("post_reset_idle", int'(busy), 0);

      // randomized packets
      for (int t = 0; t < 25; t++) begin
         sq = {};
         nv = $urandom_range(70, 0);
         for (int i = 0; i < nv; i++)
            push_sym(($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0));
         push_sync();
         push_data($urandom_range(40, 0));
         case ($urandom_range(3, 0))
            0, 1: begin push_sym(0, 1); push_sym(0, 1); push_sym(1'($urandom), 0); end
            2:    begin push_sym(0, 1); push_sym(1'($urandom), 0); end
            default: begin push_sym(0, 1); push_sym(0, 1); push_sym(0, 1); end
         endcase
         run_scn(0, 2);
      end

      check("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_rx_stream_ctrl
`default_nettype wire
